// File: rtl/advtim_run_ctrl.sv
// Run-sequence controller for advtim_cnt_gen.
// Sequences clear/arm/run/gap/done and owns the update and end flags.
module advtim_run_ctrl #(
    parameter int GAP_W = 16
) (
    input  logic             pe_gen_clk,
    input  logic             pe_gen_rstn,
    input  logic             r_cen,
    input  logic             r_opm,
    input  logic             r_ug,
    input  logic             r_udis,
    input  logic             r_urs,
    input  logic [GAP_W-1:0] r_gap,
    input  logic             r_uie,
    input  logic             r_endie,
    input  logic             uif_clr,
    input  logic             endf_clr,
    input  logic             int_status_gen_reload,
    input  logic             pe_gen_tim_end,
    output logic             pe_gen_tim_enable,
    output logic             pe_gen_logic_clr,
    output logic             cfg_update,
    output logic             cen_clr,
    output logic             uif,
    output logic             endf,
    output logic             irq,
    output logic [2:0]       run_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_hit;
    logic             rld_uev;
    logic             ug_uev;
    logic             uif_set;

    assign gap_hit = (gap_cnt == r_gap);
    assign rld_uev = int_status_gen_reload & ~r_udis & (state_q == S_RUN);
    assign ug_uev  = r_ug & ~r_cen & (state_q == S_IDLE);
    assign uif_set = rld_uev | (r_ug & ~r_urs);

    // State register; reset drops the generator enable at once.
    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in RUN disable beats ug, which beats tim_end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (r_cen) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!r_cen) begin
                    state_d = S_IDLE;
                end else if (r_ug) begin
                    state_d = S_CLR;
                end else if (pe_gen_tim_end) begin
                    state_d = r_opm ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (!r_cen) begin
                    state_d = S_IDLE;
                end else if (gap_hit) begin
                    state_d = S_ARM;
                end
            end
            S_DONE: begin
                if (!r_cen) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state plus the update event.
    always_comb begin
        pe_gen_tim_enable = 1'b0;
        pe_gen_logic_clr  = 1'b0;
        cfg_update        = rld_uev | ug_uev;
        case (state_q)
            S_CLR: begin
                pe_gen_logic_clr = 1'b1;
                cfg_update       = 1'b1;
            end
            S_ARM, S_RUN: begin
                pe_gen_tim_enable = 1'b1;
            end
            default: begin
                pe_gen_tim_enable = 1'b0;
            end
        endcase
    end

    // Idle-gap counter restarts from zero on every GAP entry.
    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            gap_cnt <= '0;
        end else if (state_q == S_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // One-cycle software-enable clear on the DONE entry cycle.
    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            cen_clr <= 1'b0;
        end else begin
            cen_clr <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    // Sticky flags; a set event wins over a same-cycle clear.
    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            uif  <= 1'b0;
            endf <= 1'b0;
        end else begin
            uif  <= uif_set | (uif & ~uif_clr);
            endf <= pe_gen_tim_end | (endf & ~endf_clr);
        end
    end

    assign irq       = (uif & r_uie) | (endf & r_endie);
    assign run_state = state_q;

endmodule

// File: tb/tb_advtim_run_ctrl.sv
// Bench for advtim_run_ctrl: directed vectors, queued expectations,
// a monitor that pops and compares one response per clock.
module tb_advtim_run_ctrl;

    localparam int GAP_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r_cen = 1'b0;
    logic             r_opm = 1'b0;
    logic             r_ug = 1'b0;
    logic             r_udis = 1'b0;
    logic             r_urs = 1'b0;
    logic [GAP_W-1:0] r_gap = '0;
    logic             r_uie = 1'b0;
    logic             r_endie = 1'b0;
    logic             uif_clr = 1'b0;
    logic             endf_clr = 1'b0;
    logic             reload = 1'b0;
    logic             tim_end = 1'b0;
    logic             tim_enable;
    logic             logic_clr;
    logic             cfg_update;
    logic             cen_clr;
    logic             uif;
    logic             endf;
    logic             irq;
    logic [2:0]       run_state;

    bit               c_rstn = 1'b0;
    bit               c_opm = 1'b0;
    bit               c_udis = 1'b0;
    bit               c_urs = 1'b0;
    bit               c_uie = 1'b0;
    bit               c_endie = 1'b0;
    bit [GAP_W-1:0]   c_gap = '0;

    typedef struct {
        string    nm;
        bit [9:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    advtim_run_ctrl #(.GAP_W(GAP_W)) dut (
        .pe_gen_clk            (clk),
        .pe_gen_rstn           (rst_n),
        .r_cen                 (r_cen),
        .r_opm                 (r_opm),
        .r_ug                  (r_ug),
        .r_udis                (r_udis),
        .r_urs                 (r_urs),
        .r_gap                 (r_gap),
        .r_uie                 (r_uie),
        .r_endie               (r_endie),
        .uif_clr               (uif_clr),
        .endf_clr              (endf_clr),
        .int_status_gen_reload (reload),
        .pe_gen_tim_end        (tim_end),
        .pe_gen_tim_enable     (tim_enable),
        .pe_gen_logic_clr      (logic_clr),
        .cfg_update            (cfg_update),
        .cen_clr               (cen_clr),
        .uif                   (uif),
        .endf                  (endf),
        .irq                   (irq),
        .run_state             (run_state)
    );

    always #5 clk = ~clk;

    function automatic bit [9:0] act_vec();
        return {run_state, tim_enable, logic_clr, cfg_update,
                cen_clr, uif, endf, irq};
    endfunction

    // Drive one vector at the falling edge; queue the response expected
    // just after the following rising edge (inputs still held).
    task automatic v(input string nm,
                     input bit cen, input bit ug, input bit rld,
                     input bit tend, input bit uclr, input bit eclr,
                     input bit [2:0] st, input bit en, input bit lc,
                     input bit cfg, input bit cc, input bit uf,
                     input bit ef, input bit iq);
        exp_t e;
        @(negedge clk);
        rst_n    = c_rstn;
        r_opm    = c_opm;
        r_udis   = c_udis;
        r_urs    = c_urs;
        r_uie    = c_uie;
        r_endie  = c_endie;
        r_gap    = c_gap;
        r_cen    = cen;
        r_ug     = ug;
        reload   = rld;
        tim_end  = tend;
        uif_clr  = uclr;
        endf_clr = eclr;
        e.nm = nm;
        e.v  = {st, en, lc, cfg, cc, uf, ef, iq};
        q.push_back(e);
    endtask

    // Monitor: one response per clock whenever an expectation is queued.
    initial begin
        exp_t e;
        bit [9:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = act_vec();
                n_cmp++;
                if (a !== e.v) begin
                    n_bad++;
                    $display("FAIL %s got st=%0d en/lc/cfg/cc/uif/endf/irq=%b need st=%0d %b",
                             e.nm, a[9:7], a[6:0], e.v[9:7], e.v[6:0]);
                end
            end
        end
    end

    initial begin
        bit [9:0] a;
        // ------------------------------- reset
        v("rst0", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        v("rst1", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        c_rstn = 1'b1;
        c_gap  = 16'd3;
        c_urs  = 1'b1;
        // ------------------------------- auto restart with gap=3
        v("A1 clr", 1,0,0,0,0,0, 1,0,1,1,0,0,0,0);
        v("A2 arm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("A3 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("A4 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("A5 rld", 1,0,1,0,0,0, 3,1,0,1,0,1,0,0);
        v("A6 uclr", 1,0,0,0,1,0, 3,1,0,0,0,0,0,0);
        v("A7 end", 1,0,0,1,0,0, 4,0,0,0,0,0,1,0);
        v("A8 gap1", 1,0,0,0,0,1, 4,0,0,0,0,0,0,0);
        v("A9 gap2", 1,0,0,0,0,0, 4,0,0,0,0,0,0,0);
        v("A10 gap3", 1,0,0,0,0,0, 4,0,0,0,0,0,0,0);
        v("A11 rearm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("A12 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("A13 end+rld", 1,0,1,1,0,0, 4,0,0,0,0,1,1,0);
        v("A14 gap off", 0,0,0,0,0,0, 0,0,0,0,0,1,1,0);
        v("A15 clr flg", 0,0,0,0,1,1, 0,0,0,0,0,0,0,0);
        // ------------------------------- ug mid-run, urs=0
        c_urs = 1'b0;
        c_uie = 1'b1;
        v("B1 clr", 1,0,0,0,0,0, 1,0,1,1,0,0,0,0);
        v("B2 arm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("B3 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("B4 ug", 1,1,0,0,0,0, 1,0,1,1,0,1,0,1);
        v("B5 arm", 1,0,0,0,0,0, 2,1,0,0,0,1,0,1);
        v("B6 run", 1,0,0,0,0,0, 3,1,0,0,0,1,0,1);
        v("B7 uclr", 1,0,0,0,1,0, 3,1,0,0,0,0,0,0);
        v("B8 off", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // ------------------------------- udis / urs on reload
        c_urs  = 1'b1;
        c_udis = 1'b1;
        c_uie  = 1'b0;
        v("C1 clr", 1,0,0,0,0,0, 1,0,1,1,0,0,0,0);
        v("C2 arm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("C3 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("C4 udis rld", 1,0,1,0,0,0, 3,1,0,0,0,0,0,0);
        c_udis = 1'b0;
        v("C5 rld", 1,0,1,0,0,0, 3,1,0,1,0,1,0,0);
        v("C6 rld+clr", 1,0,1,0,1,0, 3,1,0,1,0,1,0,0);
        v("C7 uclr", 1,0,0,0,1,0, 3,1,0,0,0,0,0,0);
        v("C8 off", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // ------------------------------- ug while idle
        v("D1 ug idle", 0,1,0,0,0,0, 0,0,0,1,0,0,0,0);
        v("D2 idle", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // ------------------------------- one-pulse mode
        c_opm   = 1'b1;
        c_endie = 1'b1;
        v("E1 clr", 1,0,0,0,0,0, 1,0,1,1,0,0,0,0);
        v("E2 arm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("E3 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("E4 done", 1,0,0,1,0,0, 5,0,0,0,1,0,1,1);
        v("E5 done", 1,0,0,0,0,0, 5,0,0,0,0,0,1,1);
        v("E6 eclr", 1,0,0,0,0,1, 5,0,0,0,0,0,0,0);
        v("E7 off", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // ------------------------------- reset during GAP
        c_opm   = 1'b0;
        c_endie = 1'b0;
        c_gap   = 16'd2;
        v("F1 clr", 1,0,0,0,0,0, 1,0,1,1,0,0,0,0);
        v("F2 arm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("F3 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("F4 end", 1,0,0,1,0,0, 4,0,0,0,0,0,1,0);
        v("F5 gap", 1,0,0,0,0,0, 4,0,0,0,0,0,1,0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        a = act_vec();
        n_cmp++;
        if (a !== 10'd0) begin
            n_bad++;
            $display("FAIL async_rst got %b need %b", a, 10'd0);
        end
        c_rstn = 1'b0;
        v("F6 in rst", 1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        c_rstn = 1'b1;
        v("F7 release", 1,0,0,0,0,0, 1,0,1,1,0,0,0,0);
        v("F8 arm", 1,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        v("F9 run", 1,0,0,0,0,0, 3,1,0,0,0,0,0,0);
        v("F10 off", 0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d left need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
